// File: rtl/zxuno_mapper_ext_if.sv
// CPU-side Z80 bus and SRAM-side strobes of the ZX-Uno memory mapper.
interface zxuno_mapper_ext_if #(
  parameter int unsigned SRAM_AW = 21
);
  logic [15:0]        a;
  logic [7:0]         din;
  logic               mreq_n;
  logic               iorq_n;
  logic               rd_n;
  logic               wr_n;
  logic               m1_n;
  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_we_n;
  logic               ram_oe_n;
  logic               bootrom_oe_n;

  modport master (
    output a, din, mreq_n, iorq_n, rd_n, wr_n, m1_n,
    input  sram_addr, sram_we_n, ram_oe_n, bootrom_oe_n
  );

  modport slave (
    input  a, din, mreq_n, iorq_n, rd_n, wr_n, m1_n,
    output sram_addr, sram_we_n, ram_oe_n, bootrom_oe_n
  );
endinterface

// File: rtl/zxuno_mapper_ext.sv
// ZX-Uno memory mapper: 128K/+3 paging with widened RAM bank, DivMMC automapper
// and mapped-page write protect. Address path is combinational from bus and state.
module zxuno_mapper_ext #(
  parameter int unsigned RAM_BANK_BITS    = 3,
  parameter int unsigned SRAM_AW          = 21,
  parameter int unsigned ROM_BASE16       = 8,
  parameter int unsigned DIVMMC_BASE8     = 64,
  parameter int unsigned DIVMMC_PAGE_BITS = 4,
  parameter int unsigned DIVMMC_ROM8      = 48
) (
  input  logic                clk,
  input  logic                rst,
  zxuno_mapper_ext_if.slave   bus,
  input  logic                boot_mode,
  input  logic [SRAM_AW-15:0] mastermapper,
  input  logic                divmmc_en,
  input  logic                divmmc_nmi_dis,
  output logic                vram_page,
  output logic                divmmc_paged,
  output logic                nmi_enable
);
  localparam int unsigned P16W     = SRAM_AW - 14;
  localparam int unsigned P8W      = SRAM_AW - 13;
  localparam int unsigned DFFD_W   = (RAM_BANK_BITS > 3) ? RAM_BANK_BITS - 3 : 1;
  localparam bit          HAS_DFFD = (RAM_BANK_BITS > 3);

  typedef enum logic [1:0] {
    ST_UNMAPPED, ST_PEND_ON, ST_MAPPED, ST_PEND_OFF
  } state_e;

  state_e                      state_q, state_d;
  logic [5:0]                  p7ffd_q, p7ffd_d;
  logic [2:0]                  p1ffd_q, p1ffd_d;
  logic [DFFD_W-1:0]           pdffd_q, pdffd_d;
  logic                        conmem_q, conmem_d;
  logic                        mapram_q, mapram_d;
  logic [DIVMMC_PAGE_BITS-1:0] page_q, page_d;

  logic io_wr, wr_7ffd, wr_1ffd, wr_dffd, wr_e3;
  logic fetch, fetch_3d, entry_pt, exit_pt, paged;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_UNMAPPED;
      p7ffd_q  <= '0;
      p1ffd_q  <= '0;
      pdffd_q  <= '0;
      conmem_q <= 1'b0;
      mapram_q <= 1'b0;
      page_q   <= '0;
    end else begin
      state_q  <= state_d;
      p7ffd_q  <= p7ffd_d;
      p1ffd_q  <= p1ffd_d;
      pdffd_q  <= pdffd_d;
      conmem_q <= conmem_d;
      mapram_q <= mapram_d;
      page_q   <= page_d;
    end
  end

  // Port write decode and automapper trigger addresses.
  always_comb begin
    io_wr    = !bus.iorq_n && !bus.wr_n;
    wr_7ffd  = io_wr && !p7ffd_q[5] && !bus.a[15] && bus.a[14] && (bus.a[1:0] == 2'b01);
    wr_1ffd  = io_wr && !p7ffd_q[5] && (bus.a[15:12] == 4'b0001) && (bus.a[1:0] == 2'b01);
    wr_dffd  = io_wr && !p7ffd_q[5] && (bus.a[15:12] == 4'b1101) && (bus.a[1:0] == 2'b01);
    wr_e3    = io_wr && (bus.a[7:0] == 8'hE3);
    fetch    = !bus.mreq_n && !bus.rd_n && !bus.m1_n;
    fetch_3d = fetch && (bus.a[15:8] == 8'h3D);
    entry_pt = fetch && ((bus.a == 16'h0000) || (bus.a == 16'h0008) ||
                         (bus.a == 16'h0038) || (bus.a == 16'h04C6) ||
                         (bus.a == 16'h0562) || ((bus.a == 16'h0066) && !divmmc_nmi_dis));
    exit_pt  = fetch && (bus.a[15:3] == 13'h03FF);
    paged    = (state_q == ST_MAPPED) || (state_q == ST_PEND_OFF);
  end

  // Register loads and automapper next state.
  always_comb begin
    p7ffd_d  = p7ffd_q;
    p1ffd_d  = p1ffd_q;
    pdffd_d  = pdffd_q;
    conmem_d = conmem_q;
    mapram_d = mapram_q;
    page_d   = page_q;
    state_d  = state_q;

    if (wr_7ffd) p7ffd_d = bus.din[5:0];
    if (wr_1ffd) p1ffd_d = bus.din[2:0];
    if (wr_dffd && HAS_DFFD) pdffd_d = bus.din[DFFD_W-1:0];
    if (wr_e3) begin
      conmem_d = bus.din[7];
      mapram_d = mapram_q | bus.din[6];
      page_d   = bus.din[DIVMMC_PAGE_BITS-1:0];
    end

    case (state_q)
      ST_UNMAPPED: begin
        if (fetch_3d)      state_d = ST_MAPPED;
        else if (entry_pt) state_d = ST_PEND_ON;
      end
      ST_PEND_ON:  if (bus.m1_n) state_d = ST_MAPPED;
      ST_MAPPED:   if (exit_pt)  state_d = ST_PEND_OFF;
      ST_PEND_OFF: begin
        if (fetch_3d)      state_d = ST_MAPPED;
        else if (bus.m1_n) state_d = ST_UNMAPPED;
      end
      default:     state_d = ST_UNMAPPED;
    endcase
    if (!divmmc_en) state_d = ST_UNMAPPED;
  end

  logic [1:0]               area;
  logic [1:0]               rom_num;
  logic [2:0]               ar_bank;
  logic [RAM_BANK_BITS-1:0] eff_bank;
  logic [P8W-1:0]           page8;
  logic                     div_map, div_prot, allram, used, writable, boot_sel;

  // Address decode: boot ROM > DivMMC > all-RAM > normal 128K map.
  always_comb begin
    area     = bus.a[15:14];
    rom_num  = {p1ffd_q[2], p7ffd_q[4]};
    eff_bank = RAM_BANK_BITS'({pdffd_q, p7ffd_q[2:0]});
    div_map  = divmmc_en && (paged || conmem_q || fetch_3d);
    div_prot = mapram_q && !conmem_q;
    allram   = p1ffd_q[0] && !boot_mode;
    case (p1ffd_q[2:1])
      2'd0:    ar_bank = {1'b0, area};
      2'd1:    ar_bank = {1'b1, area};
      2'd2:    ar_bank = (area == 2'd3) ? 3'd3 : {1'b1, area};
      default: ar_bank = (area == 2'd3) ? 3'd3 : (area == 2'd1) ? 3'd7 : {1'b1, area};
    endcase

    page8    = '0;
    used     = 1'b0;
    writable = 1'b0;
    boot_sel = 1'b0;
    if (!bus.mreq_n) begin
      used = 1'b1;
      if ((area == 2'd0) && boot_mode) begin
        used     = 1'b0;
        boot_sel = 1'b1;
      end else if ((area == 2'd0) && div_map) begin
        if (!bus.a[13]) begin
          page8 = div_prot ? P8W'(DIVMMC_BASE8 + 3) : P8W'(DIVMMC_ROM8);
        end else begin
          page8    = P8W'(DIVMMC_BASE8) + P8W'(page_q);
          writable = !(div_prot && (page_q == DIVMMC_PAGE_BITS'(3)));
        end
      end else if (allram) begin
        page8    = {P16W'(ar_bank), bus.a[13]};
        writable = 1'b1;
      end else begin
        writable = 1'b1;
        case (area)
          2'd0: begin
            page8    = {P16W'(ROM_BASE16) + P16W'(rom_num), bus.a[13]};
            writable = 1'b0;
          end
          2'd1:    page8 = {P16W'(3'd5), bus.a[13]};
          2'd2:    page8 = {P16W'(3'd2), bus.a[13]};
          default: page8 = boot_mode ? {mastermapper, bus.a[13]} : {P16W'(eff_bank), bus.a[13]};
        endcase
      end
    end

    bus.sram_addr    = used ? {page8, bus.a[12:0]} : '0;
    bus.ram_oe_n     = !(used && !bus.rd_n);
    bus.sram_we_n    = !(used && writable && !bus.wr_n);
    bus.bootrom_oe_n = !boot_sel;
  end

  assign vram_page    = p7ffd_q[3];
  assign divmmc_paged = paged;
  assign nmi_enable   = divmmc_en && paged && !divmmc_nmi_dis;
endmodule

// File: tb/tb_zxuno_mapper_ext.sv
// Randomized and directed bench for zxuno_mapper_ext against a page-table reference model.
module tb_zxuno_mapper_ext;
  localparam int unsigned RBB   = 5;
  localparam int unsigned AW    = 21;
  localparam int unsigned ROMB  = 8;
  localparam int unsigned DB8   = 64;
  localparam int unsigned DPB   = 4;
  localparam int unsigned DROM8 = 48;
  localparam int K_RD = 0, K_WR = 1, K_FETCH = 2;

  logic          clk, rst;
  logic [15:0]   a;
  logic [7:0]    din;
  logic          mreq_n, iorq_n, rd_n, wr_n, m1_n;
  logic          boot_mode, divmmc_en, nmi_dis;
  logic [AW-15:0] mastermapper;
  logic          vram_page, divmmc_paged, nmi_enable;

  zxuno_mapper_ext_if #(.SRAM_AW(AW)) bus ();
  assign bus.a      = a;
  assign bus.din    = din;
  assign bus.mreq_n = mreq_n;
  assign bus.iorq_n = iorq_n;
  assign bus.rd_n   = rd_n;
  assign bus.wr_n   = wr_n;
  assign bus.m1_n   = m1_n;

  zxuno_mapper_ext #(
    .RAM_BANK_BITS(RBB), .SRAM_AW(AW), .ROM_BASE16(ROMB),
    .DIVMMC_BASE8(DB8), .DIVMMC_PAGE_BITS(DPB), .DIVMMC_ROM8(DROM8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .boot_mode(boot_mode),
    .mastermapper(mastermapper), .divmmc_en(divmmc_en),
    .divmmc_nmi_dis(nmi_dis), .vram_page(vram_page),
    .divmmc_paged(divmmc_paged), .nmi_enable(nmi_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference state: port contents plus "mapped now" and a pending map(+1)/unmap(-1).
  logic [7:0]  m7ffd;
  logic [2:0]  m1ffd;
  int unsigned mdffd, mpage;
  logic        mconmem, mmapram, mmapped;
  int          mpend;
  int unsigned allram_map [4][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{4, 5, 6, 3}, '{4, 7, 6, 3}};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_out(output logic [31:0] ea, output logic we_n,
                                    output logic oe_n, output logic boot_n);
    int unsigned area, bank, p8;
    logic f3d, divmap, prot, wrt;
    ea = 0; we_n = 1'b1; oe_n = 1'b1; boot_n = 1'b1;
    if (mreq_n) return;
    area   = 32'(a[15:14]);
    f3d    = !rd_n && !m1_n && (a[15:8] == 8'h3D);
    divmap = divmmc_en && (mmapped || mconmem || f3d);
    prot   = mmapram && !mconmem;
    wrt    = 1'b1;
    if (area == 0 && boot_mode) begin
      boot_n = 1'b0;
      return;
    end else if (area == 0 && divmap) begin
      if (a < 16'h2000) begin
        p8  = prot ? DB8 + 3 : DROM8;
        wrt = 1'b0;
      end else begin
        p8  = DB8 + mpage;
        wrt = !(prot && mpage == 3);
      end
      ea = p8 * 8192 + 32'(a[12:0]);
    end else begin
      if (m1ffd[0] && !boot_mode) bank = allram_map[32'(m1ffd[2:1])][area];
      else if (area == 0) begin
        bank = ROMB + 2 * 32'(m1ffd[2]) + 32'(m7ffd[4]);
        wrt  = 1'b0;
      end
      else if (area == 1) bank = 5;
      else if (area == 2) bank = 2;
      else bank = boot_mode ? 32'(mastermapper) : mdffd * 8 + 32'(m7ffd[2:0]);
      ea = bank * 16384 + 32'(a[13:0]);
    end
    oe_n = rd_n;
    we_n = !(wrt && !wr_n);
  endfunction

  task automatic model_clock();
    logic io, lock, fetch, entry;
    if (rst) begin
      m7ffd = 0; m1ffd = 0; mdffd = 0; mpage = 0;
      mconmem = 0; mmapram = 0; mmapped = 0; mpend = 0;
      return;
    end
    io    = !iorq_n && !wr_n;
    lock  = m7ffd[5];
    fetch = !mreq_n && !rd_n && !m1_n;
    entry = (a == 16'h0000) || (a == 16'h0008) || (a == 16'h0038) || (a == 16'h04C6) ||
            (a == 16'h0562) || (a == 16'h0066 && !nmi_dis);
    if (!divmmc_en) begin
      mmapped = 0; mpend = 0;
    end else if (fetch) begin
      if (!mmapped && mpend == 0) begin
        if (a[15:8] == 8'h3D) mmapped = 1;
        else if (entry) mpend = 1;
      end else if (mmapped && mpend == 0 && a >= 16'h1FF8 && a <= 16'h1FFF) mpend = -1;
      else if (mpend == -1 && a[15:8] == 8'h3D) mpend = 0;
    end else if (m1_n && mpend != 0) begin
      mmapped = (mpend > 0);
      mpend   = 0;
    end
    if (io && !lock && (a & 16'hC003) == 16'h4001) m7ffd = din & 8'h3F;
    if (io && !lock && (a & 16'hF003) == 16'h1001) m1ffd = din[2:0];
    if (io && !lock && (a & 16'hF003) == 16'hD001) mdffd = 32'(din) & ((1 << (RBB - 3)) - 1);
    if (io && a[7:0] == 8'hE3) begin
      mconmem = din[7];
      if (din[6]) mmapram = 1;
      mpage = 32'(din) & ((1 << DPB) - 1);
    end
  endtask

  task automatic check_all();
    logic [31:0] ea;
    logic we, oe, bt;
    model_out(ea, we, oe, bt);
    chk("sram_addr", 32'(bus.sram_addr), ea);
    chk("sram_we_n", 32'(bus.sram_we_n), 32'(we));
    chk("ram_oe_n", 32'(bus.ram_oe_n), 32'(oe));
    chk("bootrom_oe_n", 32'(bus.bootrom_oe_n), 32'(bt));
    chk("divmmc_paged", 32'(divmmc_paged), 32'(mmapped));
    chk("nmi_enable", 32'(nmi_enable), 32'(divmmc_en && mmapped && !nmi_dis));
    chk("vram_page", 32'(vram_page), 32'(m7ffd[3]));
  endtask

  // One clock: check outputs against the model, advance model and DUT together.
  task automatic step();
    #1;
    check_all();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    a = '0; din = '0;
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
  endtask

  task automatic io_write(input logic [15:0] port, input logic [7:0] val);
    set_idle(); a = port; din = val; iorq_n = 1'b0; wr_n = 1'b0;
    step();
    set_idle();
    step();
  endtask

  task automatic mem(input logic [15:0] addr, input int kind);
    set_idle(); a = addr; mreq_n = 1'b0;
    case (kind)
      K_RD:    rd_n = 1'b0;
      K_WR:    wr_n = 1'b0;
      default: begin rd_n = 1'b0; m1_n = 1'b0; end
    endcase
  endtask

  logic [15:0] ports [4] = '{16'h7FFD, 16'h1FFD, 16'hDFFD, 16'h00E3};
  logic [15:0] hot   [10] = '{16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6,
                              16'h0562, 16'h3D00, 16'h1FF8, 16'h2000, 16'hC000};

  initial begin
    int r;
    logic [15:0] ad;
    set_idle();
    rst = 1'b1; boot_mode = 1'b0; mastermapper = '0; divmmc_en = 1'b0; nmi_dis = 1'b0;
    @(posedge clk); #1;
    model_clock();
    step();
    rst = 1'b0;

    // Basic paging and lock
    io_write(16'h7FFD, 8'h07);
    mem(16'hC000, K_RD); #1;
    chk("bank7_addr", 32'(bus.sram_addr), 32'h1C000);
    chk("bank7_oe", 32'(bus.ram_oe_n), 32'd0);
    step();
    io_write(16'h7FFD, 8'h27);
    io_write(16'h7FFD, 8'h00);
    mem(16'hC000, K_RD); #1;
    chk("locked_bank7", 32'(bus.sram_addr), 32'h1C000);
    step();
    rst = 1'b1; set_idle(); step(); rst = 1'b0;

    // Extended bank through DFFD
    io_write(16'hDFFD, 8'h03);
    io_write(16'h7FFD, 8'h06);
    mem(16'hC123, K_RD); #1;
    chk("dffd_bank30", 32'(bus.sram_addr), 32'h78123);
    step();

    // Deferred automap at 0038
    divmmc_en = 1'b1;
    mem(16'h0038, K_FETCH); #1;
    chk("fetch0038_rom", 32'(bus.sram_addr), 32'h20038);
    step();
    chk("pend_on_unpaged", 32'(divmmc_paged), 32'd0);
    set_idle();
    step();
    chk("mapped_paged", 32'(divmmc_paged), 32'd1);
    mem(16'h0000, K_RD); #1;
    chk("divrom_addr", 32'(bus.sram_addr), 32'h60000);
    step();
    mem(16'h1FF8, K_FETCH); step();
    chk("pend_off_paged", 32'(divmmc_paged), 32'd1);
    set_idle(); step();
    chk("unmapped_after_exit", 32'(divmmc_paged), 32'd0);

    // Instant map at 3Dxx
    mem(16'h3D00, K_FETCH); #1;
    chk("fetch3d_addr", 32'(bus.sram_addr), 32'h81D00);
    step();
    chk("fetch3d_paged", 32'(divmmc_paged), 32'd1);
    set_idle(); step();

    // mapram write protect
    io_write(16'h00E3, 8'h43);
    mem(16'h2000, K_WR); #1;
    chk("mapram_p3_we", 32'(bus.sram_we_n), 32'd1);
    step();
    mem(16'h0000, K_WR); #1;
    chk("mapram_rom_we", 32'(bus.sram_we_n), 32'd1);
    step();
    io_write(16'h00E3, 8'h02);
    mem(16'h2000, K_WR); #1;
    chk("page2_we", 32'(bus.sram_we_n), 32'd0);
    chk("page2_addr", 32'(bus.sram_addr), 32'h84000);
    step();

    // Reset during PEND_ON
    mem(16'h1FF8, K_FETCH); step();
    set_idle(); step();
    mem(16'h0000, K_FETCH); step();
    rst = 1'b1; set_idle(); step(); rst = 1'b0;
    chk("rst_pend_paged", 32'(divmmc_paged), 32'd0);
    step();
    chk("rst_pend_stays_off", 32'(divmmc_paged), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      set_idle();
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        a   = (r < 9) ? ports[$urandom_range(0, 3)] : 16'($urandom);
        din = 8'($urandom);
        if (a == 16'h7FFD && $urandom_range(0, 9) != 0) din[5] = 1'b0;
        iorq_n = 1'b0; wr_n = 1'b0;
      end else if (r < 70) begin
        ad = hot[$urandom_range(0, 9)];
        if (ad == 16'h3D00) ad = ad + 16'($urandom_range(0, 255));
        else if (ad == 16'h1FF8) ad = ad + 16'($urandom_range(0, 7));
        else if (ad == 16'h2000 || ad == 16'hC000) ad = ad + 16'($urandom_range(0, 16383));
        if ($urandom_range(0, 3) == 0) ad = 16'($urandom);
        mem(ad, int'($urandom_range(0, 2)));
      end else if (r < 75) begin
        m1_n = 1'b0; iorq_n = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      else rst = 1'b0;
      if ($urandom_range(0, 99) == 0) boot_mode = ~boot_mode;
      if ($urandom_range(0, 79) == 0) divmmc_en = ~divmmc_en;
      if ($urandom_range(0, 49) == 0) nmi_dis = ~nmi_dis;
      if ($urandom_range(0, 49) == 0) mastermapper = 7'($urandom);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
